// File: rtl/led_pattern_scheduler_if.sv
// Bus between the status requesters and the LED pattern scheduler.
// The master side drives the requests, patterns and counts. The slave side
// (the scheduler) drives the LED bank and the status outputs.
interface led_pattern_scheduler_if;
   logic        enable;
   logic [3:0]  req;
   logic [23:0] pattern;
   logic [11:0] count;
   logic [5:0]  LED;
   logic [1:0]  grant;
   logic        busy;
   logic [3:0]  done;

   modport master (
      output enable, req, pattern, count,
      input  LED, grant, busy, done
   );

   modport slave (
      input  enable, req, pattern, count,
      output LED, grant, busy, done
   );
endinterface

// File: rtl/led_pattern_scheduler.sv
// Time-shares the 6-bit LED bank between four requesters.
// The lowest-index active requester wins. Its pattern is played as a counted
// blink code: ON/OFF phases, then a dark GAP before the next arbitration.
// While idle, LED[0] shows a heartbeat. All phase lengths are whole ticks.
module led_pattern_scheduler #(
   parameter int TICK_DIV  = 4000000,
   parameter int ON_TICKS  = 3,
   parameter int OFF_TICKS = 3,
   parameter int GAP_TICKS = 10,
   parameter int HB_TICKS  = 10
) (
   input  logic                    clk,
   input  logic                    reset_n,
   led_pattern_scheduler_if.slave  bus
);
   localparam int PW   = $clog2(TICK_DIV);
   localparam int TM1  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int TM2  = (GAP_TICKS > HB_TICKS) ? GAP_TICKS : HB_TICKS;
   localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_e;

   state_e         state_q, state_d;
   logic [PW-1:0]  pre_q,   pre_d;
   logic [TW-1:0]  tcnt_q,  tcnt_d;   // ticks in phase; heartbeat timer in IDLE
   logic [3:0]     bcnt_q,  bcnt_d;   // current blink number, 1-based
   logic [3:0]     cnt_q,   cnt_d;    // latched blink count, 1..8
   logic [5:0]     pat_q,   pat_d;
   logic [1:0]     g_q,     g_d;
   logic           hb_q,    hb_d;
   logic [5:0]     led_q,   led_d;
   logic [3:0]     done_q,  done_d;
   logic           fin;               // sequence completes on this edge
   logic           tick;
   logic           abort;
   logic [1:0]     g_sel;
   logic [2:0]     cnt_sel;

   // Lowest set index wins; returns 0 for an empty vector.
   function automatic logic [1:0] first_set(input logic [3:0] r);
      first_set = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (r[i]) first_set = 2'(i);
   endfunction

   assign tick    = (pre_q == PW'(TICK_DIV - 1));
   assign abort   = !bus.req[g_q];
   assign g_sel   = first_set(bus.req);
   assign cnt_sel = bus.count[3*int'(g_sel) +: 3];

   // State and datapath registers; async reset clears everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         cnt_q   <= '0;
         pat_q   <= '0;
         g_q     <= '0;
         hb_q    <= 1'b0;
         led_q   <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         tcnt_q  <= tcnt_d;
         bcnt_q  <= bcnt_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         g_q     <= g_d;
         hb_q    <= hb_d;
         led_q   <= led_d;
         done_q  <= done_d;
      end
   end

   // Next-state, prescaler, phase timer and blink counter.
   always_comb begin
      state_d = state_q;
      pre_d   = tick ? '0 : pre_q + PW'(1);
      tcnt_d  = tcnt_q;
      bcnt_d  = bcnt_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      g_d     = g_q;
      hb_d    = hb_q;
      fin     = 1'b0;
      if (!bus.enable) begin
         state_d = S_IDLE;
         pre_d   = '0;
         tcnt_d  = '0;
         bcnt_d  = '0;
         hb_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req != 4'b0000) begin
                  // Grant: sample pattern/count now, restart the prescaler so
                  // the ON phase is an exact number of tick periods.
                  g_d     = g_sel;
                  pat_d   = bus.pattern[6*int'(g_sel) +: 6];
                  cnt_d   = (cnt_sel == 3'd0) ? 4'd8 : {1'b0, cnt_sel};
                  bcnt_d  = 4'd1;
                  tcnt_d  = '0;
                  pre_d   = '0;
                  state_d = S_ON;
               end else if (tick) begin
                  if (tcnt_q == TW'(HB_TICKS - 1)) begin
                     tcnt_d = '0;
                     hb_d   = ~hb_q;
                  end else begin
                     tcnt_d = tcnt_q + TW'(1);
                  end
               end
            end
            S_ON: begin
               if (abort) begin
                  // Requester went away: dark GAP of full length, no done.
                  state_d = S_GAP;
                  tcnt_d  = '0;
                  pre_d   = '0;
               end else if (tick) begin
                  if (tcnt_q == TW'(ON_TICKS - 1)) begin
                     tcnt_d = '0;
                     if (bcnt_q == cnt_q) begin
                        state_d = S_GAP;
                        fin     = 1'b1;
                     end else begin
                        state_d = S_OFF;
                     end
                  end else begin
                     tcnt_d = tcnt_q + TW'(1);
                  end
               end
            end
            S_OFF: begin
               if (abort) begin
                  state_d = S_GAP;
                  tcnt_d  = '0;
                  pre_d   = '0;
               end else if (tick) begin
                  if (tcnt_q == TW'(OFF_TICKS - 1)) begin
                     tcnt_d  = '0;
                     bcnt_d  = bcnt_q + 4'd1;
                     state_d = S_ON;
                  end else begin
                     tcnt_d = tcnt_q + TW'(1);
                  end
               end
            end
            S_GAP: begin
               if (tick) begin
                  if (tcnt_q == TW'(GAP_TICKS - 1)) begin
                     // Heartbeat restarts from dark with a fresh timer.
                     tcnt_d  = '0;
                     hb_d    = 1'b0;
                     state_d = S_IDLE;
                  end else begin
                     tcnt_d = tcnt_q + TW'(1);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Registered outputs follow the next state so LED and state change together.
   always_comb begin
      led_d  = '0;
      done_d = '0;
      case (state_d)
         S_ON:    led_d = pat_d;
         S_IDLE:  led_d = {5'b0, hb_d};
         default: led_d = '0;
      endcase
      if (fin) done_d = 4'b0001 << g_q;
   end

   assign bus.LED   = led_q;
   assign bus.grant = g_q;
   assign bus.done  = done_q;
   assign bus.busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed bench for led_pattern_scheduler with short tick settings.
// Expected LED/busy/done values per cycle are written out by hand from the
// phase lengths: tick = 4 cycles, ON = 8, OFF = 4, GAP = 12, heartbeat = 8.
module tb_led_pattern_scheduler;
   logic clk = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   led_pattern_scheduler_if bus ();

   led_pattern_scheduler #(
      .TICK_DIV (4),
      .ON_TICKS (2),
      .OFF_TICKS(1),
      .GAP_TICKS(3),
      .HB_TICKS (2)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Runs n cycles; on each falling edge checks LED, busy and done.
   // done is expected to equal done_first on the first cycle and 0 after.
   task automatic phase(input string tag, input int n, input logic [5:0] led,
                        input logic busy_e, input logic [3:0] done_first);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "_led"},  32'(bus.LED),  32'(led));
         check({tag, "_busy"}, 32'(bus.busy), 32'(busy_e));
         check({tag, "_done"}, 32'(bus.done), (i == 0) ? 32'(done_first) : 32'd0);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      bus.enable  = 1'b0;
      bus.req     = 4'b0000;
      bus.pattern = '0;
      bus.count   = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_led",   32'(bus.LED),   32'd0);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_busy",  32'(bus.busy),  32'd0);
      check("rst_done",  32'(bus.done),  32'd0);

      // Heartbeat: first toggle 8 edges after enable is sampled, then every 8
      reset_n    = 1'b1;
      bus.enable = 1'b1;
      phase("hb0", 7, 6'h00, 1'b0, 4'h0);
      phase("hb1", 8, 6'h01, 1'b0, 4'h0);
      phase("hb2", 8, 6'h00, 1'b0, 4'h0);

      // Single sequence: requester 2, pattern 2A, 3 blinks
      bus.pattern[17:12] = 6'h2A;
      bus.count[8:6]     = 3'd3;
      bus.req            = 4'b0100;
      phase("s_on1", 1, 6'h2A, 1'b1, 4'h0);
      check("s_grant", 32'(bus.grant), 32'd2);
      phase("s_on1", 7, 6'h2A, 1'b1, 4'h0);
      phase("s_off1", 4, 6'h00, 1'b1, 4'h0);
      phase("s_on2", 8, 6'h2A, 1'b1, 4'h0);
      phase("s_off2", 4, 6'h00, 1'b1, 4'h0);
      phase("s_on3", 8, 6'h2A, 1'b1, 4'h0);
      phase("s_gap", 1, 6'h00, 1'b1, 4'b0100);
      bus.req = 4'b0000;
      phase("s_gap", 11, 6'h00, 1'b1, 4'h0);
      phase("s_idle", 1, 6'h00, 1'b0, 4'h0);

      // Priority without preemption: req3 (1 blink), then req0 arrives mid-ON
      bus.pattern[23:18] = 6'h15;
      bus.count[11:9]    = 3'd1;
      bus.pattern[5:0]   = 6'h3C;
      bus.count[2:0]     = 3'd2;
      bus.req            = 4'b1000;
      phase("p_on", 3, 6'h15, 1'b1, 4'h0);
      check("p_grant3", 32'(bus.grant), 32'd3);
      bus.req = 4'b1001;
      phase("p_on", 5, 6'h15, 1'b1, 4'h0);
      check("p_grant3_hold", 32'(bus.grant), 32'd3);
      phase("p_gap", 12, 6'h00, 1'b1, 4'b1000);
      phase("p_idle", 1, 6'h00, 1'b0, 4'h0);
      phase("p_on0", 1, 6'h3C, 1'b1, 4'h0);
      check("p_grant0", 32'(bus.grant), 32'd0);
      // Dropping everything aborts requester 0 in its first ON cycle
      bus.req = 4'b0000;
      phase("p_abgap", 12, 6'h00, 1'b1, 4'h0);
      phase("p_idle2", 1, 6'h00, 1'b0, 4'h0);

      // Count 0 means 8 blinks
      bus.pattern[5:0] = 6'h3F;
      bus.count[2:0]   = 3'd0;
      bus.req          = 4'b0001;
      for (int b = 0; b < 8; b++) begin
         phase("c8_on", 8, 6'h3F, 1'b1, 4'h0);
         if (b < 7) phase("c8_off", 4, 6'h00, 1'b1, 4'h0);
      end
      phase("c8_gap", 1, 6'h00, 1'b1, 4'b0001);
      bus.req = 4'b0000;
      phase("c8_gap", 11, 6'h00, 1'b1, 4'h0);
      phase("c8_idle", 1, 6'h00, 1'b0, 4'h0);

      // Abort during the second OFF: requester 1, 4 blinks requested
      bus.pattern[11:6] = 6'h11;
      bus.count[5:3]    = 3'd4;
      bus.req           = 4'b0010;
      phase("a_on1", 8, 6'h11, 1'b1, 4'h0);
      phase("a_off1", 4, 6'h00, 1'b1, 4'h0);
      phase("a_on2", 8, 6'h11, 1'b1, 4'h0);
      phase("a_off2", 2, 6'h00, 1'b1, 4'h0);
      bus.req = 4'b0000;
      phase("a_gap", 12, 6'h00, 1'b1, 4'h0);
      phase("a_idle", 1, 6'h00, 1'b0, 4'h0);

      // Enable low during ON: dark and idle next cycle, grant held
      bus.req = 4'b0100;
      phase("e_on", 3, 6'h2A, 1'b1, 4'h0);
      bus.enable = 1'b0;
      phase("e_dis", 4, 6'h00, 1'b0, 4'h0);
      check("e_grant", 32'(bus.grant), 32'd2);
      bus.req    = 4'b0000;
      bus.enable = 1'b1;
      phase("e_idle", 2, 6'h00, 1'b0, 4'h0);

      // Asynchronous reset mid-OFF: outputs clear without a clock edge
      bus.req = 4'b0010;
      phase("r_on", 8, 6'h11, 1'b1, 4'h0);
      phase("r_off", 2, 6'h00, 1'b1, 4'h0);
      check("r_grant_pre", 32'(bus.grant), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("r_led",   32'(bus.LED),   32'd0);
      check("r_grant", 32'(bus.grant), 32'd0);
      check("r_busy",  32'(bus.busy),  32'd0);
      check("r_done",  32'(bus.done),  32'd0);
      bus.req = 4'b0000;
      @(negedge clk);
      reset_n = 1'b1;
      phase("r_idle", 2, 6'h00, 1'b0, 4'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/led_pattern_scheduler.md
# led_pattern_scheduler

Time-shares the 6-bit front-panel LED bank between four status requesters (e.g. configuration done, link error, FIFO overflow, trigger activity). It grants one requester at a time by fixed priority and plays that requester's LED pattern as a counted blink code. When no requester is active, it shows a heartbeat on LED[0]. It sits between the DIF status sources and the LED pads, and replaces direct LED toggling by individual blocks.

## Interface
- TICK_DIV, 4000000: clk cycles per tick (100 ms at 40 MHz); must be ≥ 2
- ON_TICKS, 3: ticks the pattern is lit per blink; ≥ 1
- OFF_TICKS, 3: ticks dark between blinks; ≥ 1
- GAP_TICKS, 10: ticks dark after a sequence, before re-arbitration; ≥ 1
- HB_TICKS, 10: ticks per heartbeat half-period; ≥ 1
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  block enable; low forces the idle/dark state
- req  in  4  level requests; bit 0 has the highest priority
- pattern  in  24  packed LED patterns; requester i uses bits [6i+5:6i]
- count  in  12  packed blink counts; requester i uses bits [3i+2:3i]; a value of 0 means 8 blinks
- LED  out  6  LED drive, registered
- grant  out  2  index of the current/last granted requester, registered
- busy  out  1  high while in ON, OFF or GAP
- done  out  4  one-cycle pulse on bit i when requester i's sequence completes

## Operation
- Prescaler pre: counts 0..TICK_DIV-1 and wraps. tick = (pre == TICK_DIV-1).
- pre is cleared to 0 on the cycle a grant is issued, so every phase lasts an exact multiple of TICK_DIV cycles.
- Phase timer tcnt counts ticks within the current state. Blink counter bcnt is 4 bits.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - LED = {5'b0, hb}. hb toggles every HB_TICKS ticks.
  - If req != 0, latch g = lowest set index, grant <= g, latch pattern[g] and count[g] (0 → 8), bcnt <= 1, tcnt <= 0, pre <= 0, go to ON.
  - Arbitration occurs on any cycle, not only on ticks.
- ON:
  - LED = latched pattern.
  - After ON_TICKS ticks: if bcnt == latched count, pulse done[g] and go to GAP. Otherwise go to OFF.
- OFF:
  - LED = 0.
  - After OFF_TICKS ticks: bcnt <= bcnt+1, go to ON.
- GAP:
  - LED = 0.
  - After GAP_TICKS ticks: go to IDLE. hb restarts at 0 with its timer cleared.
- Abort: if req[g] deasserts while in ON or OFF, go to GAP on the next cycle with no done pulse.
- Priority: a higher-priority request arriving mid-sequence does not preempt. It is served at the next IDLE arbitration.
- pattern and count are sampled only at grant. Later changes do not affect the running sequence.
- enable low (synchronous):
  - Next cycle: state = IDLE, LED = 0, hb = 0, pre = 0, timers = 0, done = 0.
  - No arbitration while enable is low. grant holds its value.
- Reset values: LED = 0, grant = 0, busy = 0, done = 0, state = IDLE, hb = 0, all counters = 0.

## Timing
- Grant latency: req rising in IDLE → grant/busy/LED = pattern are registered at the next clk edge (1 cycle).
- ON duration: exactly ON_TICKS×TICK_DIV cycles. OFF duration: OFF_TICKS×TICK_DIV cycles. GAP duration: GAP_TICKS×TICK_DIV cycles.
- A full sequence of N blinks lasts N×ON + (N-1)×OFF + GAP tick periods.
- done[g] is asserted in the same cycle LED first goes 0 for GAP. It is exactly 1 cycle wide.
- busy falls on the cycle the state returns to IDLE. Re-arbitration may occur on that same edge+1 if req is still set.
- Abort: LED goes 0 one cycle after req[g] falls. GAP then lasts the full GAP_TICKS.
- Asynchronous reset mid-sequence: all outputs return to reset values immediately. No done pulse is issued.
- Simultaneous requests: the lowest index wins. A request equal to the just-served one is re-served after GAP if still held (no fairness rotation).

## Test plan
- Use TICK_DIV=4, ON=2, OFF=1, GAP=3, HB=2.
- Heartbeat: reset, then enable=1 with req=0 → LED[0] toggles every 8 cycles, LED[5:1]=0, busy=0.
- Single sequence: req=4'b0100, pattern[17:12]=6'h2A, count[8:6]=3 → 3 bursts of LED=6'h2A, 8 cycles each, separated by 4 cycles dark. done[2] pulses once. 12 cycles of GAP, then IDLE.
- Priority/no-preempt: req=4'b1000 granted, then req[0] asserted mid-ON → the grant=3 sequence completes with done[3]. The next grant=0 arrives 1 cycle after the GAP ends.
- Count 0 and abort: count=0 → 8 blinks observed. Separately, drop req[g] during the second OFF → LED=0, GAP of 12 cycles, no done pulse.
- Enable and reset mid-sequence: enable=0 during ON → LED=0 the next cycle, busy=0, no done. Assert reset_n=0 asynchronously mid-OFF → all outputs 0 without waiting for a clk edge.
